conv_accum_writer: RTL and testbench
====================================

Name: conv_accum_writer

Overview:
- Downstream stage of the nine binary conv cells: consumes their 9 negative_flag bits per output pixel.
- Popcounts them, thresholds the binary dot product to one output bit, and packs 16 bits per word.
- Writes each packed word to the output SRAM at an incrementing address.
- Signals done once the final, possibly partial, word of a frame has been written.

Parameters:
- N_TAPS, 9, number of conv cells / flags per result (3x3).
- WORD_W, 16, SRAM word width; bits packed per write.
- ADDR_W, 12, SRAM address width.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous, active-low.
- start, input, 1, one-cycle pulse: begin a new output frame.
- base_addr, input, ADDR_W, first write address; sampled on start.
- neg_flags, input, N_TAPS, negative_flag from each conv cell (1 = product is -1).
- flags_valid, input, 1, neg_flags hold a valid pixel this cycle.
- flags_last, input, 1, qualified by flags_valid: this pixel is the last of the frame.
- sram_write_enable, output, 1, write strobe, one cycle per word.
- sram_write_address, output, ADDR_W, write address.
- sram_write_data, output, WORD_W, packed result word.
- busy, output, 1, high from start until done.
- done, output, 1, one-cycle pulse after the last word is written.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM returns to IDLE; pipeline valid bits, bit_ptr, pack register and word_addr are cleared.
  - All outputs read 0.
  - Reset mid-frame discards partial data; no write is issued.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: flags_valid is ignored. start loads word_addr <= base_addr, bit_ptr <= 0, pack <= 0, and moves to RUN.
  - RUN: accepts one pixel per cycle whenever flags_valid=1; bubbles are allowed. start is ignored.
  - RUN -> FLUSH when a valid pixel with flags_last=1 is accepted. flags_valid is ignored from then on.
  - FLUSH: waits until the last pixel has left the pipeline and its word has been written, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then returns to IDLE.
- busy = (state != IDLE).
- Stage 1 (registered): neg_cnt (4 bits) <= popcount(neg_flags); v1 <= flags_valid; l1 <= flags_last & flags_valid.
- Stage 2 (registered): bit b = (neg_cnt <= 4).
  - The dot product is 9 - 2*neg_cnt; it is odd, so never 0. b=1 means the result is positive.
  - b is written to pack[bit_ptr], LSB first; bit_ptr increments.
- Word completion: when bit_ptr == WORD_W-1, or l1=1, at the same edge that inserts the bit:
  - Output registers load data = pack with the new bit included, unfilled upper bits 0; address = word_addr.
  - sram_write_enable=1 for the following cycle only.
  - pack <= 0, bit_ptr <= 0, word_addr <= word_addr + 1, wrapping modulo 2^ADDR_W.
- Latency: a pixel valid in cycle c whose bit completes a word gives write_enable=1 in cycle c+2.
  - done is asserted in the cycle after the final write_enable cycle.
- Back-to-back writes: a full word followed immediately by more pixels needs no stall.
  - The output registers are separate from pack, so at most one write per 16 pixels (or per frame end).
- flags_last on a pixel that also fills bit 15 produces exactly one write, not an extra empty word.
- sram_write_address and sram_write_data hold their last values when write_enable=0. write_enable is 0 outside RUN/FLUSH.

Decomposition:
- Shared package holds:
  - N_TAPS, WORD_W and ADDR_W constants.
  - The FSM state encoding (IDLE/RUN/FLUSH/DONE, 2-bit).
  - THRESH = N_TAPS/2 (=4).
- One sub-module is natural: popcount9, a combinational adder tree from 9 bits to a 4-bit count, reusable for other kernel sizes.

Test Plan:
- base_addr=0x010, start, 16 valid pixels with neg_flags=9'h000, last on the 16th -> one write: addr 0x010, data 0xFFFF; done one cycle later; busy falls.
- 16 pixels alternating neg_cnt=4 and neg_cnt=5, starting with 4 -> data 0x5555; then a single pixel neg_flags=9'h1FF with last -> addr+1, data 0x0000.
- 20 pixels all neg_cnt=0, last on the 20th -> two writes: addr base with data 0xFFFF, then base+1 with data 0x000F; exactly two write_enable cycles.
- Same 20-pixel frame with random 1-3 cycle bubbles on flags_valid -> identical writes; write_enable only in cycle c+2 of each completing pixel.
- Reset asserted after 7 pixels accepted -> no write, all outputs 0; a new start with 16 pixels then writes correctly at the new base_addr.
- base_addr=0xFFF, 32 pixels of neg_cnt=9 with last on the 32nd -> writes at 0xFFF then 0x000, both with data 0x0000.

Source files
------------

// File: rtl/conv_accum_writer_pkg.sv
// Shared constants, FSM encoding and write payload type for the conv accumulator writer.
package conv_accum_writer_pkg;

  localparam int unsigned N_TAPS = 9;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PTR_W  = 4;
  localparam int unsigned THRESH = N_TAPS / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sram_wr_t;

endpackage

// File: rtl/conv_accum_writer_if.sv
// Pixel-flag input, SRAM write and status signals of the conv accumulator writer.
interface conv_accum_writer_if;
  import conv_accum_writer_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [N_TAPS-1:0] neg_flags;
  logic              flags_valid;
  logic              flags_last;
  logic              sram_write_enable;
  logic [ADDR_W-1:0] sram_write_address;
  logic [WORD_W-1:0] sram_write_data;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, neg_flags, flags_valid, flags_last,
    output sram_write_enable, sram_write_address, sram_write_data, busy, done
  );

  modport master (
    output start, base_addr, neg_flags, flags_valid, flags_last,
    input  sram_write_enable, sram_write_address, sram_write_data, busy, done
  );

endinterface

// File: rtl/conv_accum_writer_popcount9.sv
// Combinational population count of the nine conv-cell negative flags.
module popcount9
  import conv_accum_writer_pkg::*;
(
  input  logic [N_TAPS-1:0] bits_i,
  output logic [CNT_W-1:0]  count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      count_c = count_c + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/conv_accum_writer.sv
// Thresholds binary 3x3 dot products to one bit per pixel, packs 16 bits per word
// and writes the words to the output SRAM at incrementing addresses.
module conv_accum_writer
  import conv_accum_writer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  conv_accum_writer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  neg_cnt_q, neg_cnt_d;
  logic              v1_q, v1_d;
  logic              l1_q, l1_d;
  logic [PTR_W-1:0]  bit_ptr_q, bit_ptr_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  sram_wr_t          wr_q, wr_d;
  logic              we_q, we_d;
  logic              wr_last_q, wr_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  cnt_c;
  logic              accept_c;
  logic              bit_c;
  logic [WORD_W-1:0] pack_ins_c;

  popcount9 u_popcount (
    .bits_i  (bus.neg_flags),
    .count_c (cnt_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      neg_cnt_q   <= '0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      bit_ptr_q   <= '0;
      pack_q      <= '0;
      word_addr_q <= '0;
      wr_q        <= '0;
      we_q        <= 1'b0;
      wr_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      neg_cnt_q   <= neg_cnt_d;
      v1_q        <= v1_d;
      l1_q        <= l1_d;
      bit_ptr_q   <= bit_ptr_d;
      pack_q      <= pack_d;
      word_addr_q <= word_addr_d;
      wr_q        <= wr_d;
      we_q        <= we_d;
      wr_last_q   <= wr_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_ptr_d   = bit_ptr_q;
    pack_d      = pack_q;
    word_addr_d = word_addr_q;
    wr_d        = wr_q;
    we_d        = 1'b0;
    wr_last_d   = 1'b0;
    done_d      = 1'b0;

    // Pixels enter the pipeline only while the frame is open.
    accept_c  = (state_q == ST_RUN) && bus.flags_valid;
    neg_cnt_d = cnt_c;
    v1_d      = accept_c;
    l1_d      = accept_c && bus.flags_last;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          word_addr_d = bus.base_addr;
          bit_ptr_d   = '0;
          pack_d      = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept_c && bus.flags_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (we_q && wr_last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Odd dot product 9 - 2*cnt is positive exactly when cnt <= THRESH.
    bit_c                 = (neg_cnt_q <= CNT_W'(THRESH));
    pack_ins_c            = pack_q;
    pack_ins_c[bit_ptr_q] = bit_c;

    if (v1_q) begin
      if ((bit_ptr_q == PTR_W'(WORD_W - 1)) || l1_q) begin
        wr_d.addr   = word_addr_q;
        wr_d.data   = pack_ins_c;
        we_d        = 1'b1;
        wr_last_d   = l1_q;
        pack_d      = '0;
        bit_ptr_d   = '0;
        word_addr_d = word_addr_q + ADDR_W'(1);
      end else begin
        pack_d    = pack_ins_c;
        bit_ptr_d = bit_ptr_q + PTR_W'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.sram_write_enable  = we_q;
  assign bus.sram_write_address = wr_q.addr;
  assign bus.sram_write_data    = wr_q.data;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: tb/tb_conv_accum_writer.sv
// Directed scoreboard bench for conv_accum_writer: expected SRAM writes are queued
// as pixels are driven and matched against the write port at the negative edge.
module tb_conv_accum_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_accum_writer_if bus ();

  conv_accum_writer dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          nwr = 0;
  int          pushes = 0;
  int          last_we_cyc = -10;
  logic [15:0] m_pack;
  logic [3:0]  m_ptr;
  logic [11:0] m_addr;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [8:0] flags_n(input int k);
    logic [8:0] f;
    f = '0;
    for (int i = 0; i < k; i++) f[i] = 1'b1;
    return f;
  endfunction

  task automatic start_frame(input logic [11:0] base);
    bus.start     = 1'b1;
    bus.base_addr = base;
    m_addr = base;
    m_ptr  = '0;
    m_pack = '0;
    pushes = 0;
    nwr    = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic pixel(input logic [8:0] f, input logic last);
    exp_t e;
    bus.neg_flags   = f;
    bus.flags_valid = 1'b1;
    bus.flags_last  = last;
    m_pack[m_ptr] = ($countones(f) <= 4);
    if (m_ptr == 4'd15 || last) begin
      e.addr = m_addr;
      e.data = m_pack;
      e.cyc  = cyc + 2;
      q.push_back(e);
      pushes++;
      m_pack = '0;
      m_ptr  = '0;
      m_addr = m_addr + 12'd1;
    end else begin
      m_ptr = m_ptr + 4'd1;
    end
    @(posedge clk); #1;
    bus.flags_valid = 1'b0;
    bus.flags_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) check("done_cycle", 32'(cyc), 32'(last_we_cyc + 1));
    check("write_count", 32'(nwr), 32'(pushes));
    check("queue_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.base_addr   = '0;
    bus.neg_flags   = '0;
    bus.flags_valid = 1'b0;
    bus.flags_last  = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (bus.sram_write_enable === 1'b1) begin
          nwr++;
          last_we_cyc = cyc;
          check("write_expected", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("wr_addr", 32'(bus.sram_write_address), 32'(e.addr));
            check("wr_data", 32'(bus.sram_write_data), 32'(e.data));
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    join_none

    idle(3);
    check("rst_we", 32'(bus.sram_write_enable), 32'd0);
    check("rst_addr", 32'(bus.sram_write_address), 32'd0);
    check("rst_data", 32'(bus.sram_write_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Full word of positive results.
    start_frame(12'h010);
    for (int i = 0; i < 16; i++) pixel(flags_n(0), i == 15);
    wait_done();

    // Threshold boundary 4/5, then a lone negative pixel closing a partial word.
    start_frame(12'h100);
    for (int i = 0; i < 16; i++) pixel(flags_n((i % 2 == 0) ? 4 : 5), 1'b0);
    pixel(9'h1FF, 1'b1);
    wait_done();

    // Full word followed by a 4-bit partial word.
    start_frame(12'h020);
    for (int i = 0; i < 20; i++) pixel(flags_n(0), i == 19);
    wait_done();

    // Same frame with random bubbles on flags_valid.
    start_frame(12'h040);
    for (int i = 0; i < 20; i++) begin
      idle(int'($urandom_range(1, 3)));
      pixel(flags_n(0), i == 19);
    end
    wait_done();

    // Reset mid-frame discards partial data.
    start_frame(12'h200);
    for (int i = 0; i < 7; i++) pixel(flags_n(2), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_we", 32'(bus.sram_write_enable), 32'd0);
    check("midrst_addr", 32'(bus.sram_write_address), 32'd0);
    check("midrst_data", 32'(bus.sram_write_data), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    check("midrst_no_write", 32'(nwr), 32'd0);
    start_frame(12'h300);
    for (int i = 0; i < 16; i++) pixel(flags_n((i % 2 == 0) ? 0 : 9), i == 15);
    wait_done();

    // Address wrap at the top of the SRAM.
    start_frame(12'hFFF);
    for (int i = 0; i < 32; i++) pixel(flags_n(9), i == 31);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
